comparator_sweep_checker: RTL
=============================

# comparator_sweep_checker

Self-checking stimulus/response engine for the magnitude-comparator family. On a start pulse it drives every (A, B) operand pair into a comparator under test and holds each pair for a fixed dwell time. It samples the comparator's greater-than output, checks it against A > B, and reports an error count, the first failing pair and a pass flag. It sits opposite the comparator as its driver and checker, for on-chip self-test or as a synthesizable bench component.

## Interface
- WIDTH, 2: operand width in bits; must be ≥ 1.
- DWELL, 4: clock cycles each operand pair is held; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  level sampled each cycle; accepted only in IDLE.
- a_out  output  WIDTH  operand A to the comparator under test.
- b_out  output  WIDTH  operand B to the comparator under test.
- agb_in  input  1  comparator greater-than result (A > B).
- busy  output  1  high while the sweep is running.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  high when the last completed sweep had zero errors.
- err_count  output  2*WIDTH+1  number of mismatches in the current or last sweep.
- fail_a  output  WIDTH  A of the first mismatch.
- fail_b  output  WIDTH  B of the first mismatch.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 moves to RUN and loads A=0, B=2^WIDTH−1.
  - It clears err_count, pass, fail_a and fail_b, and resets the dwell counter to 0.
- RUN
  - The dwell counter increments each cycle.
  - When the dwell counter equals DWELL−1:
    - expected = (a_out > b_out), compared unsigned.
    - On mismatch, err_count increments. If it was 0, fail_a/fail_b capture a_out/b_out.
    - The pair then advances.
- Sweep order
  - B is the outer loop, descending from 2^WIDTH−1 to 0.
  - A is the inner loop, ascending from 0 to 2^WIDTH−1.
  - A wraps to 0 as B decrements.
- After the comparison of pair (A=max, B=0), the state moves to DONE.
- DONE
  - Lasts one cycle: done=1, busy=0.
  - pass = (err_count==0), including the final comparison.
  - The next state is IDLE.
- start is ignored in RUN and DONE; a new sweep requires start in IDLE.
- err_count width holds the worst case of 2^(2·WIDTH) errors, so no saturation is needed.
- pass, err_count, fail_a and fail_b hold their values until the next accepted start or reset.
- Reset mid-sweep aborts immediately to IDLE. No done pulse is generated and all results are cleared.

## Timing
- Reset values: state IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0.
- A start sampled at edge E0 places the first pair on a_out/b_out, with busy=1, from E0 onward.
- Each pair is stable for exactly DWELL cycles.
- agb_in is sampled at the last edge of a pair's dwell. The DUT may therefore have up to DWELL−1 cycles of output latency.
- busy is high for exactly 2^(2·WIDTH)·DWELL cycles.
  - With the defaults this is 64 cycles; done is high in the 65th cycle after E0.
- The earliest accepted restart is the cycle after done (IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package comparator_pkg contains:
  - the state enum {IDLE, RUN, DONE};
  - the function expected_agb(a, b) returning a > b, reused by comparator models and benches.
- Sub-module operand_sequencer: the dwell counter plus the A/B nested counters with wrap.
  - Inputs: load and step.
  - Outputs: a, b, dwell_last, sweep_last.
- The top level holds the FSM, the compare/accumulate logic and the result registers.

## Test plan
- Golden combinational comparator, WIDTH=2, DWELL=4, pulse start -> busy for 64 cycles; done pulse; err_count=0; pass=1.
- agb_in stuck at 0 -> err_count=6, fail_a=3, fail_b=2, pass=0.
- agb_in stuck at 1 -> err_count=10, fail_a=0, fail_b=3, pass=0.
- DUT returns A<B -> err_count=12, fail_a=0, fail_b=3. Separately, a golden DUT with one registered stage and DWELL=2 -> err_count=0, pass=1.
- rst asserted at cycle 20 of the sweep -> all outputs 0 asynchronously and no done pulse. A subsequent start runs a full, correct sweep.
- start held high throughout -> no restart during RUN or DONE. Sweeps run back-to-back with exactly one IDLE cycle between the done pulse and the next busy.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and the reference greater-than function for the comparator family.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  // Operands are passed zero-extended so one function serves every WIDTH.
  function automatic logic expected_agb(input logic [31:0] a, input logic [31:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/operand_sequencer.sv
// Dwell counter plus nested A/B operand counters: B descends as the outer loop,
// A ascends as the inner loop and wraps to 0 each time B steps down.
module operand_sequencer #(
  parameter int WIDTH = 2,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             dwell_last,
  output logic             sweep_last
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [WIDTH-1:0] OP_MAX = '1;

  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  assign a          = a_q;
  assign b          = b_q;
  assign dwell_last = (dwell_q == DWELL_LAST);
  assign sweep_last = (a_q == OP_MAX) && (b_q == '0);

  // Load starts a sweep at (A=0, B=max); each step either counts dwell or advances the pair.
  always_comb begin
    dwell_d = dwell_q;
    a_d     = a_q;
    b_d     = b_q;
    if (load) begin
      dwell_d = '0;
      a_d     = '0;
      b_d     = OP_MAX;
    end else if (step) begin
      if (dwell_last) begin
        dwell_d = '0;
        a_d     = a_q + 1'b1;
        if (a_q == OP_MAX) begin
          b_d = b_q - 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Operand and dwell registers; reset parks both operands at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      dwell_q <= dwell_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: rtl/comparator_sweep_checker.sv
// Drives every operand pair into a comparator under test, checks its A>B output
// at the end of each dwell and accumulates error count, first failure and pass flag.
module comparator_sweep_checker
  import comparator_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               agb_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  sweep_state_e     state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [2*WIDTH:0] errCount_q;
  logic [WIDTH-1:0] failA_q;
  logic [WIDTH-1:0] failB_q;

  logic [WIDTH-1:0] seqA;
  logic [WIDTH-1:0] seqB;
  logic             dwellLast;
  logic             sweepLast;
  logic             seqLoad;
  logic             seqStep;
  logic             mismatch;

  assign seqLoad  = (state_q == IDLE) && start;
  assign seqStep  = (state_q == RUN);
  assign mismatch = (agb_in != expected_agb(32'(seqA), 32'(seqB)));

  operand_sequencer #(
    .WIDTH (WIDTH),
    .DWELL (DWELL)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (seqLoad),
    .step       (seqStep),
    .a          (seqA),
    .b          (seqB),
    .dwell_last (dwellLast),
    .sweep_last (sweepLast)
  );

  assign a_out     = seqA;
  assign b_out     = seqB;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = errCount_q;
  assign fail_a    = failA_q;
  assign fail_b    = failB_q;

  // Sweep FSM with compare/accumulate; results hold until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= '0;
      failA_q    <= '0;
      failB_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            failA_q    <= '0;
            failB_q    <= '0;
          end
        end
        RUN: begin
          if (dwellLast) begin
            if (mismatch) begin
              errCount_q <= errCount_q + 1'b1;
              if (errCount_q == '0) begin
                failA_q <= seqA;
                failB_q <= seqB;
              end
            end
            if (sweepLast) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (errCount_q == '0) && !mismatch;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
